alu_shift_seq: RTL and testbench
================================

Name: alu_shift_seq

Overview:
- Multi-cycle sequencer in front of the team's 32-bit ALU.
- The ALU only shifts or rotates by one bit per operation. This block iterates a shift/rotate opcode N times (N = 0..31) by feeding the ALU result back as the next A operand.
- Arith/logic opcodes pass through as a single registered ALU cycle.
- Sits between the control unit (Start/Done handshake) and the combinational ALU, which stays external: this block drives Alu_A/Alu_B/Alu_Op and samples Alu_Out.

Parameters:
- WIDTH, 32, datapath width; must equal the ALU width.
- AMT_W, 5, shift-amount width; the maximum amount is 2**AMT_W-1.

Ports:
- Clk  in  1  rising-edge clock; single clock domain.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Op  in  4  ALU opcode for the request.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand; used by 0000-0011 only.
- Amt  in  AMT_W  iteration count for shift/rotate opcodes; ignored otherwise.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse; Result, Zero and Err are valid from this cycle.
- Result  out  WIDTH  final value; held until the next accepted Start.
- Zero  out  1  registered, equals (Result == 0).
- Err  out  1  request used an unsupported opcode.
- Alu_A  out  WIDTH  to ALU A.
- Alu_B  out  WIDTH  to ALU B.
- Alu_Op  out  4  to ALU Op.
- Alu_Out  in  WIDTH  from ALU Out.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Rst_n).
- Reset: state=IDLE. Busy, Done, Err, Zero=0. Result=0. Internal Acc, OpReg, Cnt, BReg=0.
- Reset mid-operation aborts immediately. No Done is issued for the aborted request.
- Opcode classes:
  - Single (S): 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT.
  - Iterative (I): 1000 SRA, 1001 SLL, 1010 SRL, 1100 ROL, 1101 ROR.
  - Illegal: every other code.
- Alu_A=Acc, Alu_B=BReg, Alu_Op=OpReg in every state. The ALU is combinational; its output is consumed in the same cycle.
- IDLE:
  - Start=1 latches Acc<=A, BReg<=B, OpReg<=Op.
  - Class S: Cnt<=1, go to RUN.
  - Class I with Amt>0: Cnt<=Amt, go to RUN.
  - Class I with Amt=0: Result<=A, go to DONE. No ALU cycle is used.
  - Illegal: Err<=1, Result<=0, go to DONE.
  - Start=0: stay in IDLE.
- RUN:
  - Each cycle: Acc<=Alu_Out, Cnt<=Cnt-1.
  - When Cnt==1: Result<=Alu_Out, go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Err and Zero update together with Result on entry to DONE. Err is cleared on the next accepted Start.
- Latency from the Start edge to Done high:
  - Class S: 2 cycles.
  - Class I: Amt+1 cycles.
  - Amt=0 or illegal: 1 cycle.
- Start while Busy is ignored: no queueing, no effect on the operation in progress.
- Back-to-back: a Start sampled in the first IDLE cycle after DONE is accepted. Minimum request spacing is latency+1.
- Arithmetic:
  - Wraps modulo 2**WIDTH; no carry or overflow output.
  - SRA replicates bit 31 on every iteration.
  - Rotate by 31 equals rotate by 1 in the opposite direction.
  - A shift by Amt>=WIDTH is impossible: AMT_W=5 caps Amt at 31.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SRA, OP_SLL, OP_SRL, OP_ROL, OP_ROR.
  - Function is_iter(op).
  - State encoding: S_IDLE, S_RUN, S_DONE.
  - The existing ALU can reference the same opcode constants.
- No sub-module inside the block.
- The bench instantiates the existing ALU next to alu_shift_seq and wires the Alu_* ports to it.

Test Plan:
1. Reset, then Start with Op=1001, A=0x0000_0001, Amt=4 -> Busy high; Done exactly 5 cycles after Start; Result=0x0000_0010; Zero=0; Err=0.
2. Op=1000, A=0x8000_0000, Amt=31 -> Done after 32 cycles; Result=0xFFFF_FFFF. Then Op=1010, same A and Amt -> Result=0x0000_0001.
3. Op=1101, A=0x0000_0001, Amt=1 -> Result=0x8000_0000. Then Op=1100, A=0x8000_0001, Amt=0 -> Done after 1 cycle; Result=0x8000_0001.
4. Op=0001, A=7, B=7, Amt=9 -> Done after 2 cycles; Result=0; Zero=1. Amt is ignored.
5. Op=0111 -> Done after 1 cycle; Err=1; Result=0. The next legal request (Op=0000, A=5, B=7) returns Err=0, Result=12.
6. Op=1001, Amt=20; pulse Start again mid-RUN with other operands -> second request ignored; Result=A<<20. Repeat the request and pull Rst_n low in cycle 10 -> all outputs 0 asynchronously; no Done; the next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode set, FSM encoding and opcode classifiers shared by the ALU and the
// shift sequencer in front of it.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic is_single(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_NOT);
    endfunction

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_SRA) || (op == OP_SLL) || (op == OP_SRL) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Sequencer in front of the one-bit-per-op ALU: repeats shift/rotate opcodes
// Amt times by feeding Alu_Out back as A; arith/logic opcodes take one pass.
//
// state  | meaning
// S_IDLE | waiting for Start; Result/Zero/Err hold the last outcome
// S_RUN  | one ALU pass per cycle, Cnt passes remaining
// S_DONE | Done pulse; Result/Zero/Err valid
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [AMT_W-1:0] Amt,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Err,
    output logic [WIDTH-1:0] Alu_A,
    output logic [WIDTH-1:0] Alu_B,
    output logic [3:0]       Alu_Op,
    input  logic [WIDTH-1:0] Alu_Out
);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [3:0]       op_q,     op_d;
    logic [AMT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             err_q,    err_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    acc_d = A;
                    b_d   = B;
                    op_d  = Op;
                    err_d = 1'b0;
                    if (is_single(Op)) begin
                        cnt_d   = AMT_W'(1);
                        state_d = S_RUN;
                    end else if (is_iter(Op)) begin
                        // A zero-amount shift is the identity; skip the ALU entirely.
                        if (Amt != '0) begin
                            cnt_d   = Amt;
                            state_d = S_RUN;
                        end else begin
                            result_d = A;
                            zero_d   = (A == '0);
                            state_d  = S_DONE;
                        end
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        zero_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end

            S_RUN: begin
                acc_d = Alu_Out;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    result_d = Alu_Out;
                    zero_d   = (Alu_Out == '0);
                    state_d  = S_DONE;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign Busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign Done   = (state_q == S_DONE);
    assign Result = result_q;
    assign Zero   = zero_q;
    assign Err    = err_q;
    assign Alu_A  = acc_q;
    assign Alu_B  = b_q;
    assign Alu_Op = op_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq wired to a behavioural copy of the
// combinational one-bit ALU.
module tb_alu_shift_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  amt = '0;
    logic        busy, done, zero, err;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;

    int n_chk  = 0;
    int n_pass = 0;

    alu_shift_seq #(.WIDTH(32), .AMT_W(5)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Op(op), .A(a), .B(b),
        .Amt(amt), .Busy(busy), .Done(done), .Result(result), .Zero(zero),
        .Err(err), .Alu_A(alu_a), .Alu_B(alu_b), .Alu_Op(alu_op),
        .Alu_Out(alu_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        case (alu_op)
            OP_ADD: alu_out = alu_a + alu_b;
            OP_SUB: alu_out = alu_a - alu_b;
            OP_AND: alu_out = alu_a & alu_b;
            OP_OR:  alu_out = alu_a | alu_b;
            OP_NOT: alu_out = ~alu_a;
            OP_SRA: alu_out = {alu_a[31], alu_a[31:1]};
            OP_SLL: alu_out = {alu_a[30:0], 1'b0};
            OP_SRL: alu_out = {1'b0, alu_a[31:1]};
            OP_ROL: alu_out = {alu_a[30:0], alu_a[31]};
            OP_ROR: alu_out = {alu_a[0], alu_a[31:1]};
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Start is sampled by the posedge that follows; that edge counts as cycle 1.
    task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] n);
        @(negedge clk);
        op = o; a = va; b = vb; amt = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_req(input string tag, input logic [3:0] o, input logic [31:0] va,
                           input logic [31:0] vb, input logic [4:0] n, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
        int lat;
        issue(o, va, vb, n);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(1, lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " zero"}, 32'(zero), 32'(exp_zero));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;

        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("sll4",   4'b1001, 32'h0000_0001, 32'h0, 5'd4,  5,  32'h0000_0010, 1'b0, 1'b0);
        run_req("sra31",  4'b1000, 32'h8000_0000, 32'h0, 5'd31, 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_req("srl31",  4'b1010, 32'h8000_0000, 32'h0, 5'd31, 32, 32'h0000_0001, 1'b0, 1'b0);
        run_req("ror1",   4'b1101, 32'h0000_0001, 32'h0, 5'd1,  2,  32'h8000_0000, 1'b0, 1'b0);
        run_req("rol0",   4'b1100, 32'h8000_0001, 32'h0, 5'd0,  1,  32'h8000_0001, 1'b0, 1'b0);
        run_req("rol31",  4'b1100, 32'h0000_0001, 32'h0, 5'd31, 32, 32'h8000_0000, 1'b0, 1'b0);
        run_req("sub",    4'b0001, 32'd7, 32'd7, 5'd9, 2, 32'h0, 1'b1, 1'b0);
        run_req("illegal",4'b0111, 32'h1234_5678, 32'h1, 5'd3, 1, 32'h0, 1'b1, 1'b1);
        run_req("add",    4'b0000, 32'd5, 32'd7, 5'd0, 2, 32'd12, 1'b0, 1'b0);
        run_req("not",    4'b0100, 32'h0F0F_0000, 32'h0, 5'd0, 2, 32'hF0F0_FFFF, 1'b0, 1'b0);
        run_req("or",     4'b0011, 32'hA000_0005, 32'h0500_0050, 5'd2, 2, 32'hA500_0055, 1'b0, 1'b0);

        // A second Start mid-RUN must not disturb the shift in progress.
        issue(4'b1001, 32'h0000_0003, 32'h0, 5'd20);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        op = 4'b0000; a = 32'd1; b = 32'd1; amt = 5'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore busy", 32'(busy), 32'd1);
        wait_done(7, lat);
        chk("ignore latency", 32'(lat), 32'd21);
        chk("ignore result", result, 32'h0030_0000);
        @(posedge clk); #1;
        chk("ignore idle", 32'(busy), 32'd0);

        // Abort the same request with reset during cycle 10.
        issue(4'b1001, 32'h0000_0003, 32'h0, 5'd20);
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort zero", 32'(zero), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        chk("abort alu_a", alu_a, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("abort no done", 32'(seen), 32'd0);

        run_req("after rst", 4'b0010, 32'hF0F0_00FF, 32'h0FF0_FF0F, 5'd0, 2, 32'h00F0_000F, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
